// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the system RAM port arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    HOST_ACC  = 2'd2,
    HOST_RESP = 2'd3
  } arb_state_t;

  localparam int         RAM_AW_DEF     = 11;
  localparam logic [7:0] FILL_VALUE_DEF = 8'hFF;

endpackage

// File: rtl/ram_fill_engine.sv
// Fill engine: address counter, fill_done flag and busy flag.
// The arbiter decides when the engine is active; the engine only counts.
module ram_fill_engine #(
  parameter int RAM_AW = 11
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              loading,
  input  logic              fill_active,
  output logic [RAM_AW-1:0] fill_addr,
  output logic              fill_last,
  output logic              fill_req,
  output logic              fill_busy
);

  logic fill_done;

  // One address per active cycle; wraps back to 0 after the last address.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      fill_addr <= '0;
    end else if (fill_active) begin
      fill_addr <= fill_addr + 1'b1;
    end
  end

  // fill_done is set at the last address and dropped when loading ends,
  // so the next cart load fills the banks again.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      fill_done <= 1'b0;
    end else if (!loading) begin
      fill_done <= 1'b0;
    end else if (fill_active && fill_last) begin
      fill_done <= 1'b1;
    end
  end

  assign fill_last = &fill_addr;
  assign fill_req  = loading & ~fill_done;
  assign fill_busy = fill_active;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single address/data/wren port of the two system RAM banks
// between the system bus, a host req/ack port and the cart-load fill engine.
// Optional feature macro: RAM_FILL_EN (fill engine present when defined).
//
// Host handshake: the host raises host_req with we/bank/addr/din stable and
// holds it until host_ack. host_ack is a single-cycle pulse; host_dout is
// valid in that cycle (reads) and holds until the next read. host_req still
// high in the cycle after host_ack is a new request.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int         RAM_AW     = RAM_AW_DEF,
  parameter logic [7:0] FILL_VALUE = FILL_VALUE_DEF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              loading,
  input  logic              pclk0,
  input  logic [RAM_AW-1:0] sys_addr,
  input  logic              sys_we,
  input  logic [7:0]        sys_din,
  input  logic              ram0_cs,
  input  logic              ram1_cs,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_bank,
  input  logic [RAM_AW-1:0] host_addr,
  input  logic [7:0]        host_din,
  output logic              host_ack,
  output logic [7:0]        host_dout,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram0_wren,
  output logic              ram1_wren,
  input  logic [7:0]        ram0_q,
  input  logic [7:0]        ram1_q,
  output logic              fill_busy,
  output arb_state_t        dbg_state
);

  arb_state_t        state_q, state_d;
  logic              pclk0_d;
  logic              host_slot;
  logic              sys_wr0, sys_wr1;
  logic [7:0]        dout_q, dout_d;
  logic [RAM_AW-1:0] fill_addr;
  logic              fill_last;
  logic              fill_req;

`ifdef RAM_FILL_EN
  logic fill_active;
  assign fill_active = (state_q == FILL) && !reset;

  ram_fill_engine #(.RAM_AW(RAM_AW)) u_fill (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .loading     (loading),
    .fill_active (fill_active),
    .fill_addr   (fill_addr),
    .fill_last   (fill_last),
    .fill_req    (fill_req),
    .fill_busy   (fill_busy)
  );
`else
  assign fill_addr = '0;
  assign fill_last = 1'b0;
  assign fill_req  = 1'b0;
  assign fill_busy = 1'b0;
`endif

  // The host slot is the cycle right after a bus-phase strobe, so the
  // system address is never disturbed in a pclk0 cycle or the one before.
  assign host_slot = pclk0_d & ~pclk0;
  assign sys_wr0   = sys_we & ram0_cs & pclk0 & ~loading;
  assign sys_wr1   = sys_we & ram1_cs & pclk0 & ~loading;
  assign host_dout = dout_d;

  // State, strobe history and host read data registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      pclk0_d <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      pclk0_d <= pclk0;
      dout_q  <= dout_d;
    end
  end

  // Next state and port mux. The host access is decided combinationally in
  // the slot cycle, so that cycle is reported as HOST_ACC.
  always_comb begin
    state_d   = state_q;
    dbg_state = state_q;
    ram_addr  = sys_addr;
    ram_data  = sys_din;
    ram0_wren = sys_wr0;
    ram1_wren = sys_wr1;
    host_ack  = 1'b0;
    dout_d    = dout_q;
    if (reset) begin
      state_d   = IDLE;
      dbg_state = IDLE;
      ram0_wren = 1'b0;
      ram1_wren = 1'b0;
      dout_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fill_req) begin
            state_d = FILL;
          end else if (host_slot && host_req) begin
            dbg_state = HOST_ACC;
            ram_addr  = host_addr;
            ram_data  = host_din;
            ram0_wren = host_we & ~host_bank;
            ram1_wren = host_we & host_bank;
            state_d   = HOST_RESP;
          end
        end
        FILL: begin
          ram_addr  = fill_addr;
          ram_data  = FILL_VALUE;
          ram0_wren = 1'b1;
          ram1_wren = 1'b1;
          if (fill_last) state_d = IDLE;
        end
        HOST_ACC: begin
          ram_addr  = host_addr;
          ram_data  = host_din;
          ram0_wren = host_we & ~host_bank;
          ram1_wren = host_we & host_bank;
          state_d   = HOST_RESP;
        end
        HOST_RESP: begin
          host_ack = 1'b1;
          if (!host_we) dout_d = host_bank ? ram1_q : ram0_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with bank models and a read scoreboard.
// Fill checks run when RAM_FILL_EN is defined; otherwise the bench checks
// that loading leaves the banks untouched.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int AW = 11;

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic          reset = 1'b1;
  logic          loading = 1'b0;
  logic          pclk0;
  logic          pclk0_en = 1'b1;
  logic          pclk0_prev = 1'b0;
  logic [1:0]    phase = 2'd0;
  logic [AW-1:0] sys_addr = '0;
  logic          sys_we = 1'b0;
  logic [7:0]    sys_din = '0;
  logic          ram0_cs = 1'b0, ram1_cs = 1'b0;
  logic          host_req = 1'b0, host_we = 1'b0, host_bank = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [7:0]    host_din = '0;
  logic          host_ack;
  logic [7:0]    host_dout;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_data;
  logic          ram0_wren, ram1_wren;
  logic [7:0]    ram0_q = '0, ram1_q = '0;
  logic          fill_busy;
  arb_state_t    dbg_state;

  // pclk0: one strobe every 4 cycles
  always @(posedge clk_sys) phase <= phase + 2'd1;
  assign pclk0 = pclk0_en & (phase == 2'd0);
  always @(posedge clk_sys) pclk0_prev <= pclk0;

  // bank models, 1-cycle registered read
  logic [7:0] mem0 [0:2047] = '{default: 8'h00};
  logic [7:0] mem1 [0:2047] = '{default: 8'h00};
  always @(posedge clk_sys) begin
    if (ram0_wren) mem0[ram_addr] <= ram_data;
    if (ram1_wren) mem1[ram_addr] <= ram_data;
    ram0_q <= mem0[ram_addr];
    ram1_q <= mem1[ram_addr];
  end

  ram_port_arbiter #(.RAM_AW(AW), .FILL_VALUE(8'hFF)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .loading   (loading),
    .pclk0     (pclk0),
    .sys_addr  (sys_addr),
    .sys_we    (sys_we),
    .sys_din   (sys_din),
    .ram0_cs   (ram0_cs),
    .ram1_cs   (ram1_cs),
    .host_req  (host_req),
    .host_we   (host_we),
    .host_bank (host_bank),
    .host_addr (host_addr),
    .host_din  (host_din),
    .host_ack  (host_ack),
    .host_dout (host_dout),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram0_wren (ram0_wren),
    .ram1_wren (ram1_wren),
    .ram0_q    (ram0_q),
    .ram1_q    (ram1_q),
    .fill_busy (fill_busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_pclk0();
    int n;
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (!pclk0 && n < 20);
    chk("pclk0_seen", pclk0, 1);
  endtask

  // Called at a negedge; returns at a negedge with host_req low.
  task automatic host_access(input logic we, input logic bank,
                             input logic [AW-1:0] a, input logic [7:0] d);
    int acc_n, ack_n, exp_acc;
    logic saw_busy, slot;
    logic [7:0] e;
    host_req = 1'b1; host_we = we; host_bank = bank; host_addr = a; host_din = d;
    acc_n = -1; ack_n = -1; exp_acc = -1; saw_busy = 1'b0; e = '0;
    #1;
    for (int n = 0; n < 4000 && ack_n < 0; n++) begin
      if (n > 0) begin
        @(negedge clk_sys);
        #1;
      end
      slot = pclk0_prev & ~pclk0;
      if (fill_busy) saw_busy = 1'b1;
      if (saw_busy && !fill_busy && slot && exp_acc < 0) exp_acc = n;
      if (dbg_state == HOST_ACC) begin
        acc_n = n;
        chk("host_acc_in_slot", slot, 1);
        chk("host_acc_addr", ram_addr, a);
        if (we) chk("host_acc_data", ram_data, d);
        chk("host_acc_wren0", ram0_wren, we & ~bank);
        chk("host_acc_wren1", ram1_wren, we & bank);
      end
      if (host_ack) begin
        ack_n = n;
        chk("host_ack_latency", ack_n - acc_n, 1);
        if (!we) begin
          chk("sb_nonempty", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("host_rd_data", host_dout, e);
          end
        end
      end
    end
    chk("host_ack_seen", ack_n >= 0, 1);
    if (saw_busy) chk("host_after_fill_slot", acc_n, exp_acc);
    @(negedge clk_sys);
    host_req = 1'b0;
    #1;
    chk("host_ack_pulse", host_ack, 0);
    if (!we) chk("host_dout_hold", host_dout, e);
  endtask

  task automatic host_read(input logic bank, input logic [AW-1:0] a, input logic [7:0] exp);
    exp_q.push_back(exp);
    host_access(1'b0, bank, a, 8'h00);
  endtask

`ifdef RAM_FILL_EN
  task automatic measure_fill(input int cycles, output int busy_cnt, output int runs,
                              output int first_a, output int last_a, output int bad);
    logic prev;
    prev = 1'b0; busy_cnt = 0; runs = 0; first_a = -1; last_a = -1; bad = 0;
    repeat (cycles) begin
      @(negedge clk_sys);
      #1;
      if (fill_busy) begin
        busy_cnt++;
        if (!prev) begin
          runs++;
          if (first_a < 0) first_a = int'(ram_addr);
        end
        last_a = int'(ram_addr);
        if (!(ram0_wren && ram1_wren && ram_data == 8'hFF)) bad++;
      end
      prev = fill_busy;
    end
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    int n, busy_cnt, runs, first_a, last_a, bad;
    logic [AW-1:0] ra;
    logic          rb;
    logic [7:0]    rd;

    // reset with a system write request active
    loading = 1'b1; sys_addr = 11'h2AB; sys_we = 1'b1; ram0_cs = 1'b1; ram1_cs = 1'b1;
    repeat (6) begin
      @(negedge clk_sys);
      #1;
      chk("rst_wren0", ram0_wren, 0);
      chk("rst_wren1", ram1_wren, 0);
      chk("rst_ack", host_ack, 0);
      chk("rst_dout", host_dout, 0);
      chk("rst_busy", fill_busy, 0);
      chk("rst_addr", ram_addr, 11'h2AB);
    end
    sys_we = 1'b0; ram0_cs = 1'b0; ram1_cs = 1'b0;
    reset = 1'b0;

`ifdef RAM_FILL_EN
    // full fill after reset, no second fill
    measure_fill(3000, busy_cnt, runs, first_a, last_a, bad);
    chk("fill_cycles", busy_cnt, 2048);
    chk("fill_runs", runs, 1);
    chk("fill_first_addr", first_a, 0);
    chk("fill_last_addr", last_a, 11'h7FF);
    chk("fill_port_drive", bad, 0);
    chk("fill_end_idle", dbg_state, IDLE);
    chk("fill_m0_000", mem0[11'h000], 8'hFF);
    chk("fill_m0_3ff", mem0[11'h3FF], 8'hFF);
    chk("fill_m0_7ff", mem0[11'h7FF], 8'hFF);
    chk("fill_m1_000", mem1[11'h000], 8'hFF);
    chk("fill_m1_3ff", mem1[11'h3FF], 8'hFF);
    chk("fill_m1_7ff", mem1[11'h7FF], 8'hFF);

    // reset in the middle of a fill
    loading = 1'b0;
    repeat (2) @(negedge clk_sys);
    loading = 1'b1;
    n = 0;
    do begin
      @(negedge clk_sys);
      #1;
      n++;
    end while (!(fill_busy && ram_addr == 11'h200) && n < 3000);
    chk("fill_reach_200", ram_addr, 11'h200);
    reset = 1'b1;
    #1;
    chk("midrst_busy", fill_busy, 0);
    chk("midrst_wren0", ram0_wren, 0);
    chk("midrst_wren1", ram1_wren, 0);
    @(negedge clk_sys);
    reset = 1'b0;
    measure_fill(2100, busy_cnt, runs, first_a, last_a, bad);
    chk("refill_cycles", busy_cnt, 2048);
    chk("refill_runs", runs, 1);
    chk("refill_first_addr", first_a, 0);
    chk("refill_last_addr", last_a, 11'h7FF);
`else
    // loading leaves the banks alone and blocks system writes
    sys_addr = 11'h000; sys_din = 8'h5A; sys_we = 1'b1; ram0_cs = 1'b1; ram1_cs = 1'b1;
    busy_cnt = 0; bad = 0;
    repeat (300) begin
      @(negedge clk_sys);
      #1;
      if (fill_busy) busy_cnt++;
      if (ram0_wren || ram1_wren) bad++;
    end
    sys_we = 1'b0; ram0_cs = 1'b0; ram1_cs = 1'b0;
    chk("nofill_busy", busy_cnt, 0);
    chk("nofill_wren", bad, 0);
    chk("nofill_m0_000", mem0[11'h000], 8'h00);
    chk("nofill_m1_000", mem1[11'h000], 8'h00);
`endif

    // host write / read-back across both banks
    loading = 1'b0;
    repeat (3) @(negedge clk_sys);
    host_access(1'b1, 1'b1, 11'h155, 8'hA5);
    host_read(1'b1, 11'h155, 8'hA5);
    host_access(1'b1, 1'b0, 11'h155, 8'h5A);
    host_read(1'b0, 11'h155, 8'h5A);
    host_read(1'b1, 11'h155, 8'hA5);

    // random host write/read pairs
    for (int i = 0; i < 3; i++) begin
      ra = AW'($urandom_range(1024, 2047));
      rb = 1'($urandom_range(0, 1));
      rd = 8'($urandom_range(0, 255));
      host_access(1'b1, rb, ra, rd);
      host_read(rb, ra, rd);
    end

    // host request raised in a pclk0 cycle alongside a system write
    wait_pclk0();
    sys_addr = 11'h010; sys_din = 8'h3C; sys_we = 1'b1; ram0_cs = 1'b1; ram1_cs = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_bank = 1'b0; host_addr = 11'h020; host_din = 8'h77;
    #1;
    chk("coll_state", dbg_state, IDLE);
    chk("coll_addr", ram_addr, 11'h010);
    chk("coll_data", ram_data, 8'h3C);
    chk("coll_wren0", ram0_wren, 1);
    chk("coll_wren1", ram1_wren, 0);
    host_access(1'b1, 1'b0, 11'h020, 8'h77);
    sys_we = 1'b0; ram0_cs = 1'b0;
    @(negedge clk_sys);
    chk("coll_sys_landed", mem0[11'h010], 8'h3C);
    chk("coll_host_landed", mem0[11'h020], 8'h77);
    chk("coll_m1_untouched", mem1[11'h010], 8'h00);

`ifdef RAM_FILL_EN
    // host request while a fill runs: served at the first slot after it
    loading = 1'b0;
    repeat (2) @(negedge clk_sys);
    loading = 1'b1;
    @(negedge clk_sys);
    host_read(1'b0, 11'h155, 8'hFF);
`else
    // host is served normally during loading
    loading = 1'b1;
    @(negedge clk_sys);
    host_read(1'b1, 11'h155, 8'hA5);
    chk("nofill_busy_host", fill_busy, 0);
`endif

    // system write while loading (after fill) is blocked
    wait_pclk0();
    sys_addr = 11'h030; sys_din = 8'h99; sys_we = 1'b1; ram0_cs = 1'b1; ram1_cs = 1'b1;
    #1;
    chk("load_wr_wren0", ram0_wren, 0);
    chk("load_wr_wren1", ram1_wren, 0);
    @(negedge clk_sys);
    sys_we = 1'b0; ram0_cs = 1'b0; ram1_cs = 1'b0;
`ifdef RAM_FILL_EN
    host_read(1'b0, 11'h030, 8'hFF);
    chk("load_wr_m1", mem1[11'h030], 8'hFF);
`else
    host_read(1'b0, 11'h030, 8'h00);
    chk("load_wr_m1", mem1[11'h030], 8'h00);
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
